despacho_ascensor: RTL and testbench

Parametrised elevator dispatch controller: latches floor requests, tracks the current floor from a floor-change pulse, drives the motor with a SCAN (sweep) policy, and holds the car for a programmable door dwell. It sits between the button/request front end and the motor driver. It generalises the original ten-floor algorithm block with:

- configurable floor count;
- direction memory;
- a pending-request register;
- per-floor "served" feedback.

---
 rtl/despacho_ascensor.sv | 177 +++++++++++++++++
 tb/tb_despacho_ascensor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/despacho_ascensor.sv
// Elevator dispatch controller: latches floor requests, follows the car position
// from the floor-change pulse, sweeps with a SCAN policy and holds a door dwell.
module despacho_ascensor #(
  parameter int N_PISOS  = 10,
  parameter int T_PUERTA = 8,
  localparam int W = (N_PISOS > 1) ? $clog2(N_PISOS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PISOS-1:0] solicitudes,
  input  logic               cambio_piso,
  input  logic               esperar,
  output logic [1:0]         motor,
  output logic [W-1:0]       piso_actual,
  output logic               direccion,
  output logic [1:0]         estado,
  output logic [N_PISOS-1:0] atendido
);

  localparam int CW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;
  localparam logic [W-1:0]  PISO_TOP  = W'(N_PISOS - 1);
  localparam logic [CW-1:0] CNT_CARGA = CW'(T_PUERTA - 1);

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    SUBIENDO = 2'b01,
    BAJANDO  = 2'b10,
    PARADA   = 2'b11
  } estado_t;

  estado_t             est_r, est_s;
  logic [W-1:0]        piso_r, piso_s;
  logic                dir_r, dir_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [N_PISOS-1:0]  pend_r, pend_s;
  logic [N_PISOS-1:0]  aten_r, aten_s;
  logic [1:0]          motor_r, motor_s;

  logic [N_PISOS-1:0]  nxt_s, mask_serv_s, mask_drop_s;
  logic [W-1:0]        piso_sube_s, piso_baja_s, f_serv_s;
  logic                arriba_s, abajo_s, hay_arriba_sube_s, hay_abajo_baja_s;
  logic                servir_s, drop_s;

  // Request visibility and look-ahead relative to the current and next floor
  always_comb begin
    nxt_s             = pend_r | solicitudes;
    piso_sube_s       = (piso_r == PISO_TOP) ? piso_r : piso_r + W'(1);
    piso_baja_s       = (piso_r == W'(0)) ? piso_r : piso_r - W'(1);
    arriba_s          = 1'b0;
    abajo_s           = 1'b0;
    hay_arriba_sube_s = 1'b0;
    hay_abajo_baja_s  = 1'b0;
    for (int i = 0; i < N_PISOS; i++) begin
      if (nxt_s[i] && (i > int'(piso_r)))      arriba_s          = 1'b1;
      if (nxt_s[i] && (i < int'(piso_r)))      abajo_s           = 1'b1;
      if (nxt_s[i] && (i > int'(piso_sube_s))) hay_arriba_sube_s = 1'b1;
      if (nxt_s[i] && (i < int'(piso_baja_s))) hay_abajo_baja_s  = 1'b1;
    end
  end

  // Next-state, position, direction and dwell counter decisions
  always_comb begin
    est_s    = est_r;
    piso_s   = piso_r;
    dir_s    = dir_r;
    cnt_s    = cnt_r;
    servir_s = 1'b0;
    drop_s   = 1'b0;
    f_serv_s = piso_r;
    case (est_r)
      REPOSO: begin
        if (nxt_s[piso_r]) begin
          est_s    = PARADA;
          servir_s = 1'b1;
        end else if (arriba_s && (dir_r || !abajo_s)) begin
          est_s = SUBIENDO;
          dir_s = 1'b1;
        end else if (abajo_s) begin
          est_s = BAJANDO;
          dir_s = 1'b0;
        end else begin
          est_s = REPOSO;
        end
      end
      SUBIENDO: begin
        if (cambio_piso) begin
          piso_s = piso_sube_s;
          if (nxt_s[piso_sube_s] || (piso_sube_s == PISO_TOP) || !hay_arriba_sube_s) begin
            est_s    = PARADA;
            servir_s = 1'b1;
            f_serv_s = piso_sube_s;
          end else begin
            est_s = SUBIENDO;
          end
        end else begin
          est_s = SUBIENDO;
        end
      end
      BAJANDO: begin
        if (cambio_piso) begin
          piso_s = piso_baja_s;
          if (nxt_s[piso_baja_s] || (piso_baja_s == W'(0)) || !hay_abajo_baja_s) begin
            est_s    = PARADA;
            servir_s = 1'b1;
            f_serv_s = piso_baja_s;
          end else begin
            est_s = BAJANDO;
          end
        end else begin
          est_s = BAJANDO;
        end
      end
      PARADA: begin
        // A call for the floor the car is standing at only keeps the door open
        drop_s = 1'b1;
        if (solicitudes[piso_r]) begin
          cnt_s = CNT_CARGA;
        end else if (esperar) begin
          cnt_s = cnt_r;
        end else if (cnt_r != CW'(0)) begin
          cnt_s = cnt_r - CW'(1);
        end else begin
          est_s = REPOSO;
        end
      end
      default: begin
        est_s = REPOSO;
      end
    endcase
    if (servir_s) begin
      cnt_s = CNT_CARGA;
    end else begin
      cnt_s = cnt_s;
    end
  end

  // Served/dropped masks, pending update, lamp-clear pulse and motor command
  always_comb begin
    mask_serv_s = servir_s ? (N_PISOS'(1) << f_serv_s) : '0;
    mask_drop_s = drop_s ? (N_PISOS'(1) << piso_r) : '0;
    pend_s      = nxt_s & ~mask_serv_s & ~mask_drop_s;
    aten_s      = mask_serv_s & nxt_s;
    case (est_s)
      SUBIENDO: motor_s = 2'b01;
      BAJANDO:  motor_s = 2'b10;
      default:  motor_s = 2'b00;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_r   <= REPOSO;
      piso_r  <= '0;
      dir_r   <= 1'b1;
      cnt_r   <= '0;
      pend_r  <= '0;
      aten_r  <= '0;
      motor_r <= 2'b00;
    end else begin
      est_r   <= est_s;
      piso_r  <= piso_s;
      dir_r   <= dir_s;
      cnt_r   <= cnt_s;
      pend_r  <= pend_s;
      aten_r  <= aten_s;
      motor_r <= motor_s;
    end
  end

  assign motor       = motor_r;
  assign piso_actual = piso_r;
  assign direccion   = dir_r;
  assign estado      = est_r;
  assign atendido    = aten_r;

endmodule

// File: tb/tb_despacho_ascensor.sv
// Scoreboard bench for despacho_ascensor: a floor-level reference model predicts
// each cycle's outputs and served floors; monitors compare at the falling edge.
module tb_despacho_ascensor;

  localparam int N  = 10;
  localparam int T  = 8;
  localparam int W  = $clog2(N);
  localparam int VB = 5 + W + N;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   solicitudes = '0;
  logic           cambio_piso = 1'b0;
  logic           esperar = 1'b0;
  logic [1:0]     motor;
  logic [W-1:0]   piso_actual;
  logic           direccion;
  logic [1:0]     estado;
  logic [N-1:0]   atendido;

  despacho_ascensor #(.N_PISOS(N), .T_PUERTA(T)) dut (
    .clk(clk), .rst_n(rst_n), .solicitudes(solicitudes), .cambio_piso(cambio_piso),
    .esperar(esperar), .motor(motor), .piso_actual(piso_actual), .direccion(direccion),
    .estado(estado), .atendido(atendido)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [VB-1:0] exp_q[$];
  int            ev_q[$];

  // reference model: 0 idle, 1 up, 2 down, 3 stopped at floor
  int           m_est, m_piso, m_cnt;
  bit           m_dir;
  logic [N-1:0] m_pend, m_aten;
  logic [1:0]   m_motor;

  task automatic model_reset();
    m_est = 0; m_piso = 0; m_cnt = 0; m_dir = 1'b1;
    m_pend = '0; m_aten = '0; m_motor = 2'b00;
  endtask

  function automatic bit any_above(logic [N-1:0] v, int f);
    for (int i = f + 1; i < N; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_below(logic [N-1:0] v, int f);
    for (int i = 0; i < f; i++) if (v[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_step(input logic [N-1:0] s, input logic cp, input logic e);
    logic [N-1:0] nx;
    int served, old_piso, old_est;
    nx = m_pend | s;
    served = -1; old_piso = m_piso; old_est = m_est;
    case (m_est)
      0: begin
        if (nx[m_piso]) begin m_est = 3; served = m_piso; end
        else if (any_above(nx, m_piso) && (m_dir || !any_below(nx, m_piso))) begin m_est = 1; m_dir = 1'b1; end
        else if (any_below(nx, m_piso)) begin m_est = 2; m_dir = 1'b0; end
      end
      1: if (cp) begin
        if (m_piso < N - 1) m_piso++;
        if (nx[m_piso] || m_piso == N - 1 || !any_above(nx, m_piso)) begin m_est = 3; served = m_piso; end
      end
      2: if (cp) begin
        if (m_piso > 0) m_piso--;
        if (nx[m_piso] || m_piso == 0 || !any_below(nx, m_piso)) begin m_est = 3; served = m_piso; end
      end
      default: begin
        if (s[m_piso]) m_cnt = T - 1;
        else if (!e) begin
          if (m_cnt > 0) m_cnt--;
          else m_est = 0;
        end
      end
    endcase
    if (served >= 0) m_cnt = T - 1;
    m_aten = '0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = nx[i];
      if (i == served) begin m_aten[i] = nx[i]; m_pend[i] = 1'b0; end
      if (old_est == 3 && i == old_piso) m_pend[i] = 1'b0;
    end
    m_motor = (m_est == 1) ? 2'b01 : (m_est == 2) ? 2'b10 : 2'b00;
    exp_q.push_back({m_motor, W'(m_piso), m_dir, 2'(m_est), m_aten});
    if (m_aten != '0) ev_q.push_back(served);
  endtask

  task automatic cycle(input logic [N-1:0] s, input logic cp, input logic e);
    @(negedge clk);
    #1;
    solicitudes = s; cambio_piso = cp; esperar = e;
    model_step(s, cp, e);
  endtask

  // lets the car move: one floor-sensor pulse every third cycle while driving
  task automatic travel(input int n);
    for (int k = 0; k < n; k++) cycle('0, (m_est == 1 || m_est == 2) && (k % 3 == 2), 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    logic [VB-1:0] got, req;
    got = {motor, piso_actual, direccion, estado, atendido};
    req = {2'b00, W'(0), 1'b1, 2'b00, N'(0)};
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, req);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    exp_q.delete(); ev_q.delete();
    solicitudes = '0; cambio_piso = 1'b0; esperar = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("reset_state");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // per-cycle output monitor
  always @(negedge clk) begin
    logic [VB-1:0] got, req;
    if (rst_n && exp_q.size() > 0) begin
      req = exp_q.pop_front();
      got = {motor, piso_actual, direccion, estado, atendido};
      vectors++;
      if (got !== req) begin
        miscompares++;
        $display("FAIL outputs t=%0t: got %h expected %h (motor,piso,dir,estado,atendido)", $time, got, req);
      end
    end
  end

  // served-floor event monitor
  always @(negedge clk) begin
    int f;
    if (rst_n && atendido != '0) begin
      vectors++;
      if (ev_q.size() == 0) begin
        miscompares++;
        $display("FAIL served_floor: got atendido %h expected no pulse", atendido);
      end else begin
        f = ev_q.pop_front();
        if (atendido !== (N'(1) << f)) begin
          miscompares++;
          $display("FAIL served_floor: got atendido %h expected floor %0d", atendido, f);
        end
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    apply_reset();
    // single request from reset
    cycle(N'(1) << 3, 1'b0, 1'b0);
    travel(30);
    // reach floor 5 going up, then sweep with 2, 7, 9 pending
    cycle(N'(1) << 5, 1'b0, 1'b0);
    guard = 0;
    while (m_est != 3 && guard < 40) begin travel(1); guard++; end
    cycle((N'(1) << 2) | (N'(1) << 7) | (N'(1) << 9), 1'b0, 1'b0);
    travel(150);
    // mid-travel request arriving with the sensor pulse that reaches it
    cycle(N'(1) << 6, 1'b0, 1'b0);
    guard = 0;
    while (!(m_est == 1 && m_piso == 3) && guard < 40) begin travel(1); guard++; end
    cycle('0, 1'b0, 1'b0);
    cycle(N'(1) << 4, 1'b1, 1'b0);
    travel(60);
    // door hold and same-floor reload
    cycle(N'(1) << 6, 1'b0, 1'b0);
    repeat (5) cycle('0, 1'b0, 1'b1);
    repeat (2) cycle('0, 1'b0, 1'b0);
    cycle(N'(1) << 6, 1'b0, 1'b0);
    travel(20);
    // sensor pulse while idle
    repeat (2) cycle('0, 1'b1, 1'b0);
    // run to top floor
    cycle(N'(1) << 9, 1'b0, 1'b0);
    travel(60);
    // reset while descending with requests pending
    cycle((N'(1) << 0) | (N'(1) << 3), 1'b0, 1'b0);
    travel(5);
    apply_reset();
    repeat (6) cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b1, 1'b0);
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      logic [N-1:0] s;
      logic cp;
      s = '0;
      if ($urandom_range(7) == 0) s[$urandom_range(N - 1)] = 1'b1;
      if (m_est == 1 || m_est == 2) cp = ($urandom_range(2) == 0);
      else cp = ($urandom_range(15) == 0);
      cycle(s, cp, $urandom_range(5) == 0);
    end
    cycle('0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (exp_q.size() != 0 || ev_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d entries left expected 0/0", exp_q.size(), ev_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
